// File: rtl/zigzag_rle_if.sv
// Bus bundle for zigzag_rle: block capture inputs plus the token stream.
// The master side is the encoder; the slave side is the producer/consumer around it.
interface zigzag_rle_if #(parameter int COEF_W = 12);
    logic signed [COEF_W-1:0] coeff_in [0:63];
    logic                     start;
    logic                     dc_clr;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               out_run;
    logic signed [COEF_W:0]   out_value;
    logic                     out_is_dc;
    logic                     out_last;
    logic                     done;

    modport master (
        input  coeff_in, start, dc_clr, out_ready,
        output busy, out_valid, out_run, out_value, out_is_dc, out_last, done
    );
    modport slave (
        output coeff_in, start, dc_clr, out_ready,
        input  busy, out_valid, out_run, out_value, out_is_dc, out_last, done
    );
endinterface

// File: rtl/zigzag_rle.sv
// Zigzag scan + run-length tokeniser for one 8x8 quantised block.
// Emits a DC difference token, then (run,value) AC tokens, ZRL and EOB.
module zigzag_rle #(
    parameter int COEF_W = 12
) (
    input  logic         clk,
    input  logic         rst,
    zigzag_rle_if.master bus
);
    typedef enum logic [2:0] {IDLE, DC, SCAN, ZRL, EOB} state_t;

    // Zigzag position -> raster index.
    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    state_t                   state_q, state_d;
    logic signed [COEF_W-1:0] blk_q [0:63];
    logic signed [COEF_W-1:0] blk_d [0:63];
    logic signed [COEF_W-1:0] prev_dc_q, prev_dc_d;
    logic [5:0]               k_q, k_d;
    logic [5:0]               run_q, run_d;
    logic                     done_q, done_d;

    logic                     valid, is_dc, last;
    logic [3:0]               o_run;
    logic signed [COEF_W:0]   o_val;
    logic [5:0]               zz_idx;
    logic signed [COEF_W-1:0] coef;

    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        prev_dc_d = prev_dc_q;
        k_d       = k_q;
        run_d     = run_q;
        done_d    = 1'b0;
        valid     = 1'b0;
        is_dc     = 1'b0;
        last      = 1'b0;
        o_run     = 4'd0;
        o_val     = '0;
        zz_idx    = 6'(ZZ[k_q]);
        coef      = blk_q[zz_idx];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    blk_d   = bus.coeff_in;
                    k_d     = 6'd0;
                    run_d   = 6'd0;
                    state_d = DC;
                end
            end
            DC: begin
                valid = 1'b1;
                is_dc = 1'b1;
                // One extra bit makes the difference exact for any operand pair.
                o_val = {blk_q[0][COEF_W-1], blk_q[0]} - {prev_dc_q[COEF_W-1], prev_dc_q};
                if (bus.out_ready) begin
                    prev_dc_d = blk_q[0];
                    k_d       = 6'd1;
                    run_d     = 6'd0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (coef == '0) begin
                    if (k_q == 6'd63) begin
                        state_d = EOB;
                    end else begin
                        k_d   = k_q + 6'd1;
                        run_d = run_q + 6'd1;
                    end
                end else if (run_q >= 6'd16) begin
                    state_d = ZRL;
                end else begin
                    valid = 1'b1;
                    o_run = run_q[3:0];
                    o_val = {coef[COEF_W-1], coef};
                    last  = (k_q == 6'd63);
                    if (bus.out_ready) begin
                        run_d = 6'd0;
                        k_d   = k_q + 6'd1;
                        if (last) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            k_d     = 6'd0;
                        end
                    end
                end
            end
            ZRL: begin
                valid = 1'b1;
                o_run = 4'd15;
                if (bus.out_ready) begin
                    run_d = run_q - 6'd16;
                    if (run_q < 6'd32) state_d = SCAN;
                end
            end
            EOB: begin
                valid = 1'b1;
                last  = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    k_d     = 6'd0;
                    run_d   = 6'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clearing wins over the predictor update on the DC handshake.
        if (bus.dc_clr) prev_dc_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_dc_q <= '0;
            k_q       <= 6'd0;
            run_q     <= 6'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_dc_q <= prev_dc_d;
            k_q       <= k_d;
            run_q     <= run_d;
            done_q    <= done_d;
        end
    end

    // Block buffer is only read after a capture, so it needs no reset.
    always_ff @(posedge clk) begin
        blk_q <= blk_d;
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = valid;
    assign bus.out_run   = o_run;
    assign bus.out_value = o_val;
    assign bus.out_is_dc = is_dc;
    assign bus.out_last  = last;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_zigzag_rle.sv
// Bench for zigzag_rle: directed token tables, hand-written corner sequences,
// and random blocks checked against a queue-based reference tokeniser.
module tb_zigzag_rle;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    zigzag_rle_if #(.COEF_W(W)) bus();
    zigzag_rle #(.COEF_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [3:0]        run;
        logic signed [W:0] val;
        logic              dc;
        logic              last;
    } tok_t;

    typedef struct {
        int          i0, v0, i1, v1;
        bit          clr;
        int          n;
        tok_t [0:4]  t;
    } vec_t;

    tok_t               exp_q[$];
    vec_t               vt[$];
    logic signed [W-1:0] cur_blk [0:63];
    int                 zz [64];
    int                 nvec, nfail, mdl_prev, gap;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic tok_t tk(input int r, input int v, input bit d, input bit l);
        tok_t t;
        t.run = 4'(r); t.val = (W+1)'(v); t.dc = d; t.last = l;
        return t;
    endfunction

    function automatic tok_t cur_tok();
        tok_t t;
        t.run = bus.out_run; t.val = bus.out_value; t.dc = bus.out_is_dc; t.last = bus.out_last;
        return t;
    endfunction

    // Zigzag order derived from anti-diagonals: even ones walk up-right, odd ones down-left.
    function automatic void build_zz();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 8) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
            end
        end
    endfunction

    function automatic void model(input bit clr);
        int run = 0;
        if (clr) mdl_prev = 0;
        exp_q.delete();
        exp_q.push_back(tk(0, int'(cur_blk[0]) - mdl_prev, 1'b1, 1'b0));
        mdl_prev = int'(cur_blk[0]);
        for (int k = 1; k < 64; k++) begin
            int v = int'(cur_blk[zz[k]]);
            if (v == 0) run++;
            else begin
                while (run >= 16) begin exp_q.push_back(tk(15, 0, 1'b0, 1'b0)); run -= 16; end
                exp_q.push_back(tk(run, v, 1'b0, k == 63));
                run = 0;
            end
        end
        if (cur_blk[zz[63]] == 0) exp_q.push_back(tk(0, 0, 1'b0, 1'b1));
    endfunction

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) cur_blk[i] = '0;
    endtask

    // Entered and left on a negedge; compares every accepted token with exp_q.
    task automatic run_block(input bit clr, input int rdy_pct, input int stall_at, input bit poke);
        int   cyc = 0, ti = 0, stall = 0;
        bit   fin = 0, rdy;
        tok_t got, snap;
        gap = 0;
        snap = '0;
        bus.coeff_in = cur_blk; bus.start = 1'b1; bus.dc_clr = clr;
        @(negedge clk);
        bus.start = 1'b0; bus.dc_clr = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        while (!fin && cyc < 3000) begin
            rdy = ($urandom_range(99) < rdy_pct);
            if (!bus.out_valid) gap++;
            if (poke && cyc == 5) begin
                for (int i = 0; i < 64; i++) bus.coeff_in[i] = W'($urandom);
                bus.start = 1'b1;
            end else bus.start = 1'b0;
            if (bus.out_valid && ti == stall_at) begin
                if (stall == 0) snap = cur_tok();
                else chk("hold_stable", 32'(cur_tok()), 32'(snap));
                if (stall < 5) begin rdy = 1'b0; stall++; end
                else rdy = 1'b1;
            end
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                got = cur_tok();
                if (exp_q.size() == 0) begin
                    nvec++; nfail++;
                    $display("FAIL extra_token: got %0h expected none", got);
                    fin = 1;
                end else chk($sformatf("token%0d", ti), 32'(got), 32'(exp_q.pop_front()));
                ti++;
                if (got.last) fin = 1;
            end
            @(negedge clk); cyc++;
        end
        bus.out_ready = 1'b0; bus.start = 1'b0;
        if (!fin) begin
            nvec++; nfail++;
            $display("FAIL block_timeout: got no last token, expected one within 3000 cycles");
            rst = 1'b1; @(negedge clk); rst = 1'b0; mdl_prev = 0;
        end else begin
            chk("done_pulse", {30'd0, bus.done, bus.busy}, 32'd2);
            chk("tokens_left", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            chk("idle_after", {29'd0, bus.busy, bus.done, bus.out_valid}, 32'd0);
        end
    endtask

    task automatic add_vec(input int i0, v0, i1, v1, input bit clr, input int n,
                           input tok_t a, b, c, d, e);
        vec_t v;
        v.i0 = i0; v.v0 = v0; v.i1 = i1; v.v1 = v1; v.clr = clr; v.n = n;
        v.t[0] = a; v.t[1] = b; v.t[2] = c; v.t[3] = d; v.t[4] = e;
        vt.push_back(v);
    endtask

    initial begin
        tok_t z, eob, zrl;
        nvec = 0; nfail = 0; mdl_prev = 0;
        build_zz();
        z = '0; eob = tk(0, 0, 0, 1); zrl = tk(15, 0, 0, 0);
        bus.start = 1'b0; bus.dc_clr = 1'b0; bus.out_ready = 1'b0;
        clear_blk(); bus.coeff_in = cur_blk;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {bus.busy, bus.out_valid, bus.out_run, bus.out_value,
                              bus.out_is_dc, bus.out_last, bus.done}, 32'd0);
        rst = 1'b0;

        // Directed table: coefficient pair, dc_clr, expected token list.
        add_vec(0, 0, 0, 0, 1, 2, tk(0, 0, 1, 0), eob, z, z, z);
        add_vec(0, 50, 0, 50, 1, 2, tk(0, 50, 1, 0), eob, z, z, z);
        add_vec(0, 30, 0, 30, 0, 2, tk(0, -20, 1, 0), eob, z, z, z);
        add_vec(0, 50, 0, 50, 0, 2, tk(0, 20, 1, 0), eob, z, z, z);
        add_vec(0, 30, 0, 30, 1, 2, tk(0, 30, 1, 0), eob, z, z, z);
        add_vec(63, -5, 0, 0, 1, 5, tk(0, 0, 1, 0), zrl, zrl, zrl, tk(14, -5, 0, 1));
        add_vec(1, 7, 8, -3, 0, 4, tk(0, 0, 1, 0), tk(0, 7, 0, 0), tk(0, -3, 0, 0), eob, z);
        add_vec(0, -2048, 0, -2048, 0, 2, tk(0, -2048, 1, 0), eob, z, z, z);
        add_vec(0, 2047, 0, 2047, 0, 2, tk(0, 4095, 1, 0), eob, z, z, z);
        add_vec(19, 9, 0, 0, 1, 4, tk(0, 0, 1, 0), zrl, tk(0, 9, 0, 0), eob, z);
        add_vec(12, -1, 0, 0, 0, 3, tk(0, 0, 1, 0), tk(15, -1, 0, 0), eob, z, z);
        add_vec(2, 4, 3, 1, 0, 4, tk(0, 0, 1, 0), tk(4, 4, 0, 0), tk(0, 1, 0, 0), eob, z);

        foreach (vt[i]) begin
            clear_blk();
            cur_blk[vt[i].i0] = W'(vt[i].v0);
            cur_blk[vt[i].i1] = W'(vt[i].v1);
            exp_q.delete();
            for (int j = 0; j < vt[i].n; j++) exp_q.push_back(vt[i].t[j]);
            run_block(vt[i].clr, 100, -1, 1'b0);
            if (i == 0) chk("eob_gap_cycles", 32'(gap), 32'd63);
        end
        mdl_prev = 0;

        // Consumer stalls five cycles on the (0,7) token.
        clear_blk(); cur_blk[1] = 12'sd7; cur_blk[8] = -12'sd3;
        model(1'b1);
        run_block(1'b1, 100, 1, 1'b0);

        // start pulsed mid-block with different data must be ignored.
        clear_blk(); cur_blk[0] = 12'sd9; cur_blk[27] = 12'sd3; cur_blk[62] = -12'sd8;
        model(1'b0);
        run_block(1'b0, 100, -1, 1'b1);

        // Reset while a token is being presented, then DC restarts from zero.
        clear_blk(); cur_blk[0] = 12'sd100; cur_blk[1] = 12'sd5;
        bus.coeff_in = cur_blk; bus.start = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.out_ready = 1'b0;
        chk("pre_reset_token", {31'd0, bus.out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", {bus.busy, bus.out_valid, bus.out_run, bus.out_value,
                                       bus.out_is_dc, bus.out_last, bus.done}, 32'd0);
        @(negedge clk); rst = 1'b0;
        clear_blk(); cur_blk[0] = 12'sd40;
        mdl_prev = 0;
        model(1'b0);
        run_block(1'b0, 100, -1, 1'b0);

        // Random blocks of varying density against the reference tokeniser.
        for (int b = 0; b < 40; b++) begin
            int dens = $urandom_range(0, 40);
            bit clr  = ($urandom_range(0, 3) == 0);
            clear_blk();
            cur_blk[0] = W'($urandom);
            for (int i = 1; i < 64; i++)
                if ($urandom_range(99) < dens) cur_blk[i] = W'($urandom);
            if (b % 8 == 3) cur_blk[zz[$urandom_range(40, 63)]] = W'($urandom_range(1, 2047));
            model(clr);
            run_block(clr, $urandom_range(30, 100), -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/zigzag_rle.md
ZIGZAG_RLE -- requirements
Module: zigzag_rle

Interface
REQ-001 SHALL have parameter COEF_W, default 12, the signed coefficient width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-004 SHALL have port coeff_in [0:63], input, 64 x COEF_W signed, the quantized block in raster order (row*8+col).
REQ-005 SHALL have port start, input, 1, a request to capture coeff_in and encode it.
REQ-006 SHALL have port dc_clr, input, 1, which clears the DC predictor.
REQ-007 SHALL have port busy, output, 1, high from capture until the final token handshake.
REQ-008 SHALL have port out_valid, output, 1, token valid.
REQ-009 SHALL have port out_ready, input, 1, token accepted by the consumer.
REQ-010 SHALL have port out_run, output, 4, the zero-run length preceding the value.
REQ-011 SHALL have port out_value, output, COEF_W+1 signed, the coefficient or DC difference.
REQ-012 SHALL have port out_is_dc, output, 1, high for the DC token.
REQ-013 SHALL have port out_last, output, 1, high on the final token of a block.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse after the final handshake.

Function
REQ-015 SHALL implement states IDLE, DC, SCAN, ZRL and EOB.
REQ-016 In IDLE with start=1, SHALL latch all 64 coeff_in values into an internal buffer, set busy=1 and enter DC at the same edge.
REQ-017 SHALL ignore start while busy=1.
REQ-018 In DC, SHALL present out_valid=1, out_is_dc=1, out_run=0 and out_value=buf[0]-prev_dc, sign-extended to COEF_W+1.
- The DC token is first valid in the cycle after the start edge.
REQ-019 On the DC handshake, SHALL set prev_dc=buf[0], k=1 and run=0, and enter SCAN.
REQ-020 A handshake SHALL be the condition out_valid and out_ready at a rising edge.
REQ-021 While out_valid=1 and out_ready=0, SHALL hold all out_* signals stable.
REQ-022 SHALL scan k=1..63 in standard JPEG zigzag order (raster index sequence 0,1,8,16,9,2,3,10,17,24,...,47,55,62,63), using a 64-entry constant table.
REQ-023 In SCAN, a zero coefficient SHALL increment run and k in one cycle with out_valid=0.
REQ-024 In SCAN, a nonzero coefficient with run<=15 SHALL present (out_run=run, out_value=coefficient).
- On handshake: run=0, k=k+1.
REQ-025 In SCAN, a nonzero coefficient with run>=16 SHALL enter ZRL.
- ZRL presents (out_run=15, out_value=0); each handshake sets run=run-16.
- ZRL returns to SCAN without advancing k once run<16.
REQ-026 If k=63 is zero, or all of k=1..63 are zero, SHALL enter EOB and present (out_run=0, out_value=0, out_last=1).
- Pending runs of 16 or more are not emitted as ZRL.
REQ-027 If the coefficient at k=63 is nonzero, its token SHALL carry out_last=1 and no EOB SHALL follow.
REQ-028 On the out_last handshake, SHALL return to IDLE with busy=0 and done=1 for exactly the next cycle.
- start is accepted again in that same cycle.
REQ-029 SHALL keep out_is_dc=0 on all non-DC tokens and out_last=0 on all non-final tokens.
REQ-030 dc_clr=1 in any cycle SHALL set prev_dc=0.
- When dc_clr and start are high in the same IDLE cycle, the new block's DC difference SHALL use prev_dc=0.
- dc_clr during the DC handshake edge SHALL take priority over the prev_dc update.
REQ-031 SHALL perform DC subtraction in COEF_W+1 bits, which cannot overflow.

Reset
REQ-032 On rst=1, SHALL immediately and asynchronously force state=IDLE, busy=0, out_valid=0, out_run=0, out_value=0, out_is_dc=0, out_last=0, done=0, prev_dc=0, k=0 and run=0.
REQ-033 On rst mid-block, SHALL discard the block.
- The first block after reset deasserts SHALL use prev_dc=0.
REQ-034 Buffer contents after reset SHALL be don't-care; they are not observable.

Verification
REQ-035 All-zero block, prev_dc=0: expect DC token (0,0,is_dc=1), then 63 cycles without a token, then EOB (0,0,last=1), then done pulse.
REQ-036 Block A buf[0]=50 then block B buf[0]=30, other coefficients zero: expect DC values 50 then -20; with dc_clr pulsed between the blocks, expect 50 then 30.
REQ-037 Only raster[63]=-5 nonzero, DC=0: expect DC token, 3 x ZRL (15,0), then (14,-5) with last=1, and no EOB.
REQ-038 raster[1]=7 and raster[8]=-3, rest zero: expect DC, (0,7), (0,-3), then EOB.
REQ-039 Hold out_ready=0 for 5 cycles on the (0,7) token: expect out_* stable and no token lost or duplicated.
REQ-040 Cover the following mid-operation events:
- Assert rst during SCAN: expect all outputs 0 immediately, and the next block reports DC equal to buf[0].
- Pulse start while busy: expect it ignored.
